multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control unit: a Moore FSM that sequences fetch, decode, execute,
// memory, write-back, mult/div and exception handling over a shared wait counter.
module multicycle_ctrl #(
   parameter int MEM_WAIT      = 1,
   parameter int MULDIV_CYCLES = 32,
   parameter int RESET_HOLD    = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       overflow,
   input  logic       div_zero,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       ir_write,
   output logic       mem_read,
   output logic       mem_write,
   output logic       i_or_d,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic       muldiv_start,
   output logic       muldiv_sel,
   output logic       epc_write,
   output logic       rst_out,
   output logic [2:0] alu_op,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_source,
   output logic [1:0] reg_dst,
   output logic [1:0] mem_to_reg,
   output logic [3:0] state_out
);

   typedef enum logic [3:0] {
      S_RESET  = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_EXEC_R = 4'd3,
      S_EXEC_I = 4'd4,
      S_WB     = 4'd5,
      S_ADDR   = 4'd6,
      S_MEM_RD = 4'd7,
      S_MEM_WB = 4'd8,
      S_MEM_WR = 4'd9,
      S_BRANCH = 4'd10,
      S_JUMP   = 4'd11,
      S_MULDIV = 4'd12,
      S_EXCEPT = 4'd13
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_MULT = 6'h18;
   localparam logic [5:0] FN_DIV  = 6'h1A;

   localparam logic [2:0] ALU_ADD = 3'b001;
   localparam logic [2:0] ALU_SUB = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;

   // Counter reload values: each counted state runs until the counter reaches zero.
   localparam logic [7:0] WAIT_LOAD   = 8'(MEM_WAIT);
   localparam logic [7:0] MULDIV_LOAD = 8'(MULDIV_CYCLES - 1);
   localparam logic [7:0] RESET_LOAD  = 8'(RESET_HOLD - 1);

   state_t     state;
   state_t     state_next;
   logic [7:0] cnt;
   logic [7:0] cnt_next;

   logic is_rtype;
   logic is_alu_r;
   logic is_muldiv;
   logic is_div;
   logic ov_traps;
   logic cnt_done;
   logic zero_unused;

   // The branch decision is made in the datapath from pc_write_cond and zero.
   assign zero_unused = zero;

   assign is_rtype  = (opcode == OP_RTYPE);
   assign is_alu_r  = is_rtype && ((funct == FN_ADD) || (funct == FN_SUB) ||
                                   (funct == FN_AND) || (funct == FN_SLT));
   assign is_muldiv = is_rtype && ((funct == FN_MULT) || (funct == FN_DIV));
   assign is_div    = (funct == FN_DIV);
   assign ov_traps  = (funct == FN_ADD) || (funct == FN_SUB);
   assign cnt_done  = (cnt == 8'd0);
   assign state_out = state;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_RESET;
         cnt   <= RESET_LOAD;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Next state plus counter: decrement saturating at zero, reload on every state change.
   always_comb begin
      state_next = state;
      cnt_next   = cnt_done ? cnt : cnt - 8'd1;
      case (state)
         S_RESET:  if (cnt_done) state_next = S_FETCH;
         S_FETCH:  if (cnt_done) state_next = S_DECODE;
         S_DECODE: begin
            if (is_alu_r) begin
               state_next = S_EXEC_R;
            end else if (is_muldiv) begin
               state_next = (is_div && div_zero) ? S_EXCEPT : S_MULDIV;
            end else begin
               case (opcode)
                  OP_ADDI:      state_next = S_EXEC_I;
                  OP_LW, OP_SW: state_next = S_ADDR;
                  OP_BEQ:       state_next = S_BRANCH;
                  OP_J:         state_next = S_JUMP;
                  default:      state_next = S_EXCEPT;
               endcase
            end
         end
         S_EXEC_R: state_next = (overflow && ov_traps) ? S_EXCEPT : S_WB;
         S_EXEC_I: state_next = overflow ? S_EXCEPT : S_WB;
         S_ADDR:   state_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD: if (cnt_done) state_next = S_MEM_WB;
         S_MEM_WR: if (cnt_done) state_next = S_FETCH;
         S_MULDIV: if (cnt_done) state_next = S_FETCH;
         default:  state_next = S_FETCH;
      endcase

      if (state_next != state) begin
         case (state_next)
            S_FETCH, S_MEM_RD, S_MEM_WR: cnt_next = WAIT_LOAD;
            S_MULDIV:                    cnt_next = MULDIV_LOAD;
            S_RESET:                     cnt_next = RESET_LOAD;
            default:                     cnt_next = 8'd0;
         endcase
      end
   end

   // Moore outputs; instruction-register fields only select among per-state variants.
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      i_or_d        = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      muldiv_start  = 1'b0;
      muldiv_sel    = 1'b0;
      epc_write     = 1'b0;
      rst_out       = 1'b0;
      alu_op        = 3'b000;
      alu_src_b     = 2'b00;
      pc_source     = 2'b00;
      reg_dst       = 2'b00;
      mem_to_reg    = 2'b00;
      case (state)
         S_RESET: rst_out = 1'b1;
         S_FETCH: begin
            mem_read = 1'b1;
            if (cnt_done) begin
               ir_write  = 1'b1;
               pc_write  = 1'b1;
               alu_src_b = 2'b01;
               alu_op    = ALU_ADD;
            end
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            alu_op    = ALU_ADD;
         end
         S_EXEC_R: begin
            alu_src_a = 1'b1;
            case (funct)
               FN_ADD:  alu_op = ALU_ADD;
               FN_SUB:  alu_op = ALU_SUB;
               FN_AND:  alu_op = ALU_AND;
               FN_SLT:  alu_op = ALU_SLT;
               default: alu_op = 3'b000;
            endcase
         end
         S_EXEC_I, S_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = ALU_ADD;
         end
         S_WB: begin
            reg_write = 1'b1;
            reg_dst   = is_rtype ? 2'b01 : 2'b00;
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 2'b01;
         end
         S_MEM_WR: begin
            i_or_d    = 1'b1;
            mem_write = cnt_done;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = ALU_SUB;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
         end
         S_MULDIV: begin
            muldiv_start = (cnt == MULDIV_LOAD);
            muldiv_sel   = is_div;
         end
         S_EXCEPT: begin
            epc_write = 1'b1;
            pc_write  = 1'b1;
            pc_source = 2'b11;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected output traces are queued when an
// instruction is applied and popped one per clock as the controller steps through it.
module tb_multicycle_ctrl;

   localparam int MEM_WAIT      = 2;
   localparam int MULDIV_CYCLES = 32;
   localparam int RESET_HOLD    = 3;

   localparam int K_RESET  = 0;
   localparam int K_FETCH  = 1;
   localparam int K_DECODE = 2;
   localparam int K_EXEC_R = 3;
   localparam int K_EXEC_I = 4;
   localparam int K_WB     = 5;
   localparam int K_ADDR   = 6;
   localparam int K_MEM_RD = 7;
   localparam int K_MEM_WB = 8;
   localparam int K_MEM_WR = 9;
   localparam int K_BRANCH = 10;
   localparam int K_JUMP   = 11;
   localparam int K_MULDIV = 12;
   localparam int K_EXCEPT = 13;

   string kindName [14] = '{"RESET", "FETCH", "DECODE", "EXEC_R", "EXEC_I", "WB", "ADDR",
                            "MEM_RD", "MEM_WB", "MEM_WR", "BRANCH", "JUMP", "MULDIV", "EXCEPT"};

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] opcode = 6'h00;
   logic [5:0] funct = 6'h00;
   logic       zero = 1'b0;
   logic       overflow = 1'b0;
   logic       div_zero = 1'b0;
   logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d, reg_write;
   logic       alu_src_a, muldiv_start, muldiv_sel, epc_write, rst_out;
   logic [2:0] alu_op;
   logic [1:0] alu_src_b, pc_source, reg_dst, mem_to_reg;
   logic [3:0] state_out;

   typedef struct packed {
      logic       rst_out, pc_write, pc_write_cond, ir_write, mem_read, mem_write;
      logic       i_or_d, reg_write, alu_src_a, muldiv_start, muldiv_sel, epc_write;
      logic [2:0] alu_op;
      logic [1:0] alu_src_b, pc_source, reg_dst, mem_to_reg;
   } out_t;

   typedef struct {
      int   kind;
      out_t word;
   } exp_t;

   typedef enum int {P_R, P_R_OV, P_I, P_I_OV, P_LW, P_SW, P_BR, P_J, P_MD, P_EXC} path_t;

   typedef struct {
      string      name;
      logic [5:0] opcode;
      logic [5:0] funct;
      logic       zero;
      logic       overflow;
      logic       div_zero;
      path_t      path;
      logic [2:0] expAlu;
      logic       expSel;
   } vec_t;

   exp_t       sb[$];
   vec_t       vectors[19];
   int         nCompared = 0;
   int         nMismatched = 0;
   int         cycleNo = 0;
   logic [3:0] codeOf[14];
   bit         codeKnown[14];

   always #5 clock = ~clock;

   multicycle_ctrl #(
      .MEM_WAIT(MEM_WAIT),
      .MULDIV_CYCLES(MULDIV_CYCLES),
      .RESET_HOLD(RESET_HOLD)
   ) dut (
      .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
      .overflow(overflow), .div_zero(div_zero), .pc_write(pc_write),
      .pc_write_cond(pc_write_cond), .ir_write(ir_write), .mem_read(mem_read),
      .mem_write(mem_write), .i_or_d(i_or_d), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .muldiv_start(muldiv_start), .muldiv_sel(muldiv_sel), .epc_write(epc_write),
      .rst_out(rst_out), .alu_op(alu_op), .alu_src_b(alu_src_b), .pc_source(pc_source),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .state_out(state_out)
   );

   function automatic vec_t mkVec(string name, logic [5:0] op, logic [5:0] fn, logic z,
                                  logic ov, logic dz, path_t p, logic [2:0] alu, logic sel);
      vec_t v;
      v.name = name; v.opcode = op; v.funct = fn; v.zero = z; v.overflow = ov;
      v.div_zero = dz; v.path = p; v.expAlu = alu; v.expSel = sel;
      return v;
   endfunction

   function automatic out_t sampleOut();
      out_t o;
      o.rst_out = rst_out; o.pc_write = pc_write; o.pc_write_cond = pc_write_cond;
      o.ir_write = ir_write; o.mem_read = mem_read; o.mem_write = mem_write;
      o.i_or_d = i_or_d; o.reg_write = reg_write; o.alu_src_a = alu_src_a;
      o.muldiv_start = muldiv_start; o.muldiv_sel = muldiv_sel; o.epc_write = epc_write;
      o.alu_op = alu_op; o.alu_src_b = alu_src_b; o.pc_source = pc_source;
      o.reg_dst = reg_dst; o.mem_to_reg = mem_to_reg;
      return o;
   endfunction

   task automatic pushExp(input int kind, input out_t w);
      exp_t e;
      e.kind = kind;
      e.word = w;
      sb.push_back(e);
   endtask

   task automatic pushReset(input int n);
      out_t w = '0;
      w.rst_out = 1'b1;
      for (int i = 0; i < n; i++) pushExp(K_RESET, w);
   endtask

   task automatic pushFetchDecode();
      out_t w;
      for (int i = 0; i <= MEM_WAIT; i++) begin
         w = '0;
         w.mem_read = 1'b1;
         if (i == MEM_WAIT) begin
            w.ir_write = 1'b1; w.pc_write = 1'b1; w.alu_src_b = 2'b01; w.alu_op = 3'b001;
         end
         pushExp(K_FETCH, w);
      end
      w = '0;
      w.alu_src_b = 2'b11; w.alu_op = 3'b001;
      pushExp(K_DECODE, w);
   endtask

   task automatic pushMulDiv(input logic sel, input int n);
      out_t w;
      for (int i = 0; i < n; i++) begin
         w = '0;
         w.muldiv_start = (i == 0);
         w.muldiv_sel = sel;
         pushExp(K_MULDIV, w);
      end
   endtask

   task automatic pushMemRd(input int n);
      out_t w = '0;
      w.mem_read = 1'b1; w.i_or_d = 1'b1;
      for (int i = 0; i < n; i++) pushExp(K_MEM_RD, w);
   endtask

   // Drive one instruction and queue the full output trace it should produce.
   task automatic applyStimulus(input vec_t v);
      out_t w;
      out_t wAddI;
      out_t wExc;
      opcode = v.opcode; funct = v.funct; zero = v.zero;
      overflow = v.overflow; div_zero = v.div_zero;
      wAddI = '0; wAddI.alu_src_a = 1'b1; wAddI.alu_src_b = 2'b10; wAddI.alu_op = 3'b001;
      wExc = '0; wExc.epc_write = 1'b1; wExc.pc_write = 1'b1; wExc.pc_source = 2'b11;
      pushFetchDecode();
      case (v.path)
         P_R, P_R_OV: begin
            w = '0; w.alu_src_a = 1'b1; w.alu_op = v.expAlu;
            pushExp(K_EXEC_R, w);
            if (v.path == P_R) begin
               w = '0; w.reg_write = 1'b1; w.reg_dst = 2'b01;
               pushExp(K_WB, w);
            end else begin
               pushExp(K_EXCEPT, wExc);
            end
         end
         P_I, P_I_OV: begin
            pushExp(K_EXEC_I, wAddI);
            if (v.path == P_I) begin
               w = '0; w.reg_write = 1'b1;
               pushExp(K_WB, w);
            end else begin
               pushExp(K_EXCEPT, wExc);
            end
         end
         P_LW: begin
            pushExp(K_ADDR, wAddI);
            pushMemRd(MEM_WAIT + 1);
            w = '0; w.reg_write = 1'b1; w.mem_to_reg = 2'b01;
            pushExp(K_MEM_WB, w);
         end
         P_SW: begin
            pushExp(K_ADDR, wAddI);
            for (int i = 0; i <= MEM_WAIT; i++) begin
               w = '0; w.i_or_d = 1'b1; w.mem_write = (i == MEM_WAIT);
               pushExp(K_MEM_WR, w);
            end
         end
         P_BR: begin
            w = '0; w.alu_src_a = 1'b1; w.alu_op = 3'b010;
            w.pc_write_cond = 1'b1; w.pc_source = 2'b01;
            pushExp(K_BRANCH, w);
         end
         P_J: begin
            w = '0; w.pc_write = 1'b1; w.pc_source = 2'b10;
            pushExp(K_JUMP, w);
         end
         P_MD:    pushMulDiv(v.expSel, MULDIV_CYCLES);
         default: pushExp(K_EXCEPT, wExc);
      endcase
   endtask

   // One clock: compare the outputs and the state code against the next queued entry.
   task automatic checkOutput();
      exp_t e;
      out_t act;
      bit   clash;
      @(negedge clock);
      cycleNo++;
      nCompared++;
      if (sb.size() == 0) begin
         nMismatched++;
         $display("[TB] FAIL scoreboard_empty cycle %0d: got no entry required one", cycleNo);
         return;
      end
      e = sb.pop_front();
      act = sampleOut();
      if (act !== e.word) begin
         nMismatched++;
         $display("[TB] FAIL outputs_%s cycle %0d: got %h required %h",
                  kindName[e.kind], cycleNo, act, e.word);
      end
      nCompared++;
      if (codeKnown[e.kind]) begin
         if (state_out !== codeOf[e.kind]) begin
            nMismatched++;
            $display("[TB] FAIL state_out_%s cycle %0d: got %h required %h",
                     kindName[e.kind], cycleNo, state_out, codeOf[e.kind]);
         end
      end else begin
         clash = $isunknown(state_out);
         for (int k = 0; k < 14; k++)
            if (codeKnown[k] && codeOf[k] == state_out) clash = 1'b1;
         if (clash) begin
            nMismatched++;
            $display("[TB] FAIL state_out_unique_%s cycle %0d: got %h required a fresh code",
                     kindName[e.kind], cycleNo, state_out);
         end
         codeKnown[e.kind] = 1'b1;
         codeOf[e.kind] = state_out;
      end
   endtask

   task automatic drainQueue();
      while (sb.size() > 0) checkOutput();
   endtask

   initial begin
      vectors[0]  = mkVec("add",        6'h00, 6'h20, 0, 0, 0, P_R,    3'b001, 0);
      vectors[1]  = mkVec("sub",        6'h00, 6'h22, 0, 0, 0, P_R,    3'b010, 0);
      vectors[2]  = mkVec("and_ov",     6'h00, 6'h24, 0, 1, 0, P_R,    3'b011, 0);
      vectors[3]  = mkVec("slt_ov",     6'h00, 6'h2A, 0, 1, 0, P_R,    3'b100, 0);
      vectors[4]  = mkVec("add_ov",     6'h00, 6'h20, 0, 1, 0, P_R_OV, 3'b001, 0);
      vectors[5]  = mkVec("sub_ov",     6'h00, 6'h22, 0, 1, 0, P_R_OV, 3'b010, 0);
      vectors[6]  = mkVec("addi",       6'h08, 6'h15, 0, 0, 0, P_I,    3'b001, 0);
      vectors[7]  = mkVec("addi_ov",    6'h08, 6'h00, 0, 1, 0, P_I_OV, 3'b001, 0);
      vectors[8]  = mkVec("lw",         6'h23, 6'h00, 0, 0, 0, P_LW,   3'b001, 0);
      vectors[9]  = mkVec("sw",         6'h2B, 6'h00, 0, 0, 0, P_SW,   3'b001, 0);
      vectors[10] = mkVec("beq_taken",  6'h04, 6'h00, 1, 0, 0, P_BR,   3'b010, 0);
      vectors[11] = mkVec("beq_not",    6'h04, 6'h00, 0, 0, 0, P_BR,   3'b010, 0);
      vectors[12] = mkVec("j",          6'h02, 6'h00, 0, 0, 0, P_J,    3'b000, 0);
      vectors[13] = mkVec("bad_op",     6'h3F, 6'h00, 0, 0, 0, P_EXC,  3'b000, 0);
      vectors[14] = mkVec("bad_funct",  6'h00, 6'h21, 0, 0, 0, P_EXC,  3'b000, 0);
      vectors[15] = mkVec("mult",       6'h00, 6'h18, 0, 0, 0, P_MD,   3'b000, 0);
      vectors[16] = mkVec("div",        6'h00, 6'h1A, 0, 0, 0, P_MD,   3'b000, 1);
      vectors[17] = mkVec("div_zero",   6'h00, 6'h1A, 0, 0, 1, P_EXC,  3'b000, 0);
      vectors[18] = mkVec("mult_dz",    6'h00, 6'h18, 0, 0, 1, P_MD,   3'b000, 0);

      // Reset visible for two cycles, then held RESET_HOLD more; first FETCH on cycle 6.
      reset = 1'b1;
      @(posedge clock);
      #1;
      pushReset(2 + RESET_HOLD);
      checkOutput();
      checkOutput();
      @(posedge clock);
      #1 reset = 1'b0;
      drainQueue();

      foreach (vectors[i]) begin
         applyStimulus(vectors[i]);
         drainQueue();
      end

      // Reset during MULDIV cycle 10 aborts the operation with no further start pulse.
      opcode = 6'h00; funct = 6'h1A; overflow = 1'b0; div_zero = 1'b0; zero = 1'b0;
      pushFetchDecode();
      pushMulDiv(1'b1, 10);
      drainQueue();
      reset = 1'b1;
      pushReset(RESET_HOLD);
      checkOutput();
      reset = 1'b0;
      drainQueue();
      applyStimulus(vectors[12]);
      drainQueue();

      // Reset in the middle of a load's memory wait.
      opcode = 6'h23; funct = 6'h00;
      pushFetchDecode();
      begin
         out_t w = '0;
         w.alu_src_a = 1'b1; w.alu_src_b = 2'b10; w.alu_op = 3'b001;
         pushExp(K_ADDR, w);
      end
      pushMemRd(2);
      drainQueue();
      reset = 1'b1;
      pushReset(RESET_HOLD);
      checkOutput();
      reset = 1'b0;
      drainQueue();
      applyStimulus(vectors[0]);
      drainQueue();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
